// File: rtl/iomem_timer_if.sv
// iomem bus bundle between the CPU (master) and a memory-mapped peripheral (slave).
interface iomem_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_timer.sv
// Memory-mapped down-counting timer with prescaler, one-shot/auto-reload modes
// and a write-1-to-clear pending flag driving a level interrupt.
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic   clk,
  input  logic   sreset,
  iomem_if.slave iomem,
  output logic   irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_RELOAD   = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_NONE     = 3'd7;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      else         res[8*i +: 8] = old_val[8*i +: 8];
    end
    return res;
  endfunction

  logic                      enable_r, auto_reload_r, irq_en_r, pending_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r, pcnt_r;
  logic [31:0]               reload_r, count_r, rdata_r;
  logic                      ready_r, done_r, irq_r;

  logic                      enable_n, auto_reload_n, irq_en_n, pending_n;
  logic [PRESCALE_WIDTH-1:0] prescale_n, pcnt_n;
  logic [31:0]               reload_n, count_n;

  logic        sel_s, ack_s, wr_s, tick_s, expire_s;
  logic [2:0]  offset_s;
  logic [31:0] prescale_ext_s, rd_val_s, wmerge_s;
  logic        unused_s;

  assign unused_s       = ^iomem.addr[1:0];
  assign sel_s          = iomem.valid && (iomem.addr[31:5] == BASE_ADDR[31:5]);
  // done_r blocks a second ack while the same request is still held
  assign ack_s          = sel_s && !ready_r && !done_r;
  assign wr_s           = ack_s && (iomem.wstrb != 4'b0000);
  assign offset_s       = iomem.addr[4:2];
  assign prescale_ext_s = 32'(prescale_r);
  assign tick_s         = enable_r && (pcnt_r == prescale_r);
  assign expire_s       = tick_s && (count_r == 32'd0);
  assign wmerge_s       = merge_lanes(rd_val_s, iomem.wdata, iomem.wstrb);

  assign iomem.ready = ready_r;
  assign iomem.rdata = rdata_r;
  assign irq         = irq_r;

  // Register read multiplexer
  always_comb begin
    rd_val_s = 32'd0;
    case (offset_s)
      OFF_CTRL:     rd_val_s = {29'd0, irq_en_r, auto_reload_r, enable_r};
      OFF_PRESCALE: rd_val_s = prescale_ext_s;
      OFF_RELOAD:   rd_val_s = reload_r;
      OFF_COUNT:    rd_val_s = count_r;
      OFF_STATUS:   rd_val_s = {31'd0, pending_r};
      default:      rd_val_s = 32'd0;
    endcase
  end

  // Next-state: timer tick effects first, then bus writes override them
  always_comb begin
    enable_n      = enable_r;
    auto_reload_n = auto_reload_r;
    irq_en_n      = irq_en_r;
    prescale_n    = prescale_r;
    reload_n      = reload_r;
    count_n       = count_r;
    pending_n     = pending_r;
    pcnt_n        = (enable_r && !tick_s) ? (pcnt_r + PRESCALE_WIDTH'(1)) : '0;

    if (expire_s) begin
      pending_n = 1'b1;
      if (auto_reload_r) count_n = reload_r;
      else               enable_n = 1'b0;
    end else if (tick_s) begin
      count_n = count_r - 32'd1;
    end else begin
      count_n = count_r;
    end

    // Non-write cycles fall through to default via OFF_NONE
    case (wr_s ? offset_s : OFF_NONE)
      OFF_CTRL: begin
        enable_n      = iomem.wstrb[0] ? iomem.wdata[0] : enable_n;
        auto_reload_n = iomem.wstrb[0] ? iomem.wdata[1] : auto_reload_n;
        irq_en_n      = iomem.wstrb[0] ? iomem.wdata[2] : irq_en_n;
      end
      OFF_PRESCALE: prescale_n = wmerge_s[PRESCALE_WIDTH-1:0];
      OFF_RELOAD:   reload_n   = wmerge_s;
      OFF_COUNT:    count_n    = wmerge_s;
      OFF_STATUS:   pending_n  = pending_n && !(iomem.wstrb[0] && iomem.wdata[0] && !expire_s);
      default:      reload_n   = reload_r;
    endcase
  end

  // State and registered bus/irq outputs
  always_ff @(posedge clk) begin
    if (sreset) begin
      enable_r      <= 1'b0;
      auto_reload_r <= 1'b0;
      irq_en_r      <= 1'b0;
      pending_r     <= 1'b0;
      prescale_r    <= '0;
      pcnt_r        <= '0;
      reload_r      <= 32'd0;
      count_r       <= 32'd0;
      rdata_r       <= 32'd0;
      ready_r       <= 1'b0;
      done_r        <= 1'b0;
      irq_r         <= 1'b0;
    end else begin
      enable_r      <= enable_n;
      auto_reload_r <= auto_reload_n;
      irq_en_r      <= irq_en_n;
      pending_r     <= pending_n;
      prescale_r    <= prescale_n;
      pcnt_r        <= pcnt_n;
      reload_r      <= reload_n;
      count_r       <= count_n;
      rdata_r       <= ack_s ? rd_val_s : 32'd0;
      ready_r       <= ack_s;
      done_r        <= iomem.valid && (done_r || ready_r);
      irq_r         <= pending_r && irq_en_r;
    end
  end

endmodule

// File: tb/tb_iomem_timer.sv
// Self-checking bench for iomem_timer: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_iomem_timer;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam int          PW   = 16;

  logic clk = 1'b0;
  logic sreset = 1'b1;
  logic irq;
  iomem_if bus ();

  iomem_timer #(.BASE_ADDR(BASE), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .sreset(sreset), .iomem(bus), .irq(irq));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Behavioural model: register file plus tick/expiry rules in plain arithmetic
  typedef struct {
    bit en, ar, ie, pend, ready, held, irq;
    int unsigned presc, pcnt;
    bit [31:0] reload, count, rdata;
  } mstate_t;

  mstate_t m = '{default: 0};

  function automatic mstate_t model_next(mstate_t s, bit rst, bit valid, bit [3:0] strb,
                                         bit [31:0] addr, bit [31:0] wdata);
    mstate_t n;
    bit hit, ack, tick, expire;
    bit [31:0] rv, merged;
    n = s;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    hit = valid && (addr[31:5] == BASE[31:5]);
    ack = hit && !s.ready && !s.held;
    case (addr[4:2])
      3'd0: rv = {29'd0, s.ie, s.ar, s.en};
      3'd1: rv = s.presc;
      3'd2: rv = s.reload;
      3'd3: rv = s.count;
      3'd4: rv = {31'd0, s.pend};
      default: rv = 32'd0;
    endcase
    n.ready = ack;
    n.held  = valid && (s.held || s.ready);
    n.rdata = ack ? rv : 32'd0;
    n.irq   = s.pend && s.ie;
    tick    = s.en && (s.pcnt == s.presc);
    n.pcnt  = (!s.en || tick) ? 0 : (s.pcnt + 1) % (1 << PW);
    expire  = tick && (s.count == 0);
    if (tick && !expire) n.count = s.count - 1;
    if (expire) begin
      n.pend = 1'b1;
      if (s.ar) n.count = s.reload;
      else      n.en = 1'b0;
    end
    if (ack && strb != 4'b0) begin
      merged = rv;
      for (int i = 0; i < 4; i++) if (strb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      case (addr[4:2])
        3'd0: if (strb[0]) begin n.en = wdata[0]; n.ar = wdata[1]; n.ie = wdata[2]; end
        3'd1: n.presc = merged % (1 << PW);
        3'd2: n.reload = merged;
        3'd3: n.count = merged;
        3'd4: if (strb[0] && wdata[0] && !expire) n.pend = 1'b0;
        default: ;
      endcase
    end
    return n;
  endfunction

  // Advance the model and the cycle counter on every clock edge
  always @(posedge clk) begin
    m   <= model_next(m, sreset, bus.valid, bus.wstrb, bus.addr, bus.wdata);
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock, then compare DUT outputs against the model
  task automatic step();
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("model_ready", {31'd0, bus.ready}, {31'd0, m.ready});
      check("model_rdata", bus.rdata, m.rdata);
      check("model_irq", {31'd0, irq}, {31'd0, m.irq});
    end
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    bus.valid = 1'b1; bus.addr = addr; bus.wstrb = strb; bus.wdata = wdata;
    lat = -1; rdata = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus.ready === 1'b1) begin
        lat = i; rdata = bus.rdata;
        break;
      end
    end
    bus.valid = 1'b0; bus.wstrb = 4'b0;
    step();
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    logic [31:0] rd; int lat;
    bus_xfer(BASE + off, 4'hF, data, rd, lat);
    check("wr_latency", lat, 1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd; int lat;
    bus_xfer(BASE + off, 4'h0, 32'd0, rd, lat);
    check("rd_latency", lat, 1);
    check(name, rd, exp);
  endtask

  task automatic wait_irq(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (irq === 1'b1) begin at = cyc; break; end
    end
    check("irq_timeout", {31'd0, at >= 0}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] off;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    int c0, c1, c2, acks, lat;
    logic [31:0] rd;
    bus.valid = 1'b0; bus.wstrb = 4'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    sreset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sreset = 1'b0;
    chk_en = 1'b1;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_ready", {31'd0, bus.ready}, 32'd0);

    // Register access vectors (timer disabled)
    vt = '{
      '{32'h00, 4'h0, 32'h0, 32'h0}, '{32'h04, 4'h0, 32'h0, 32'h0},
      '{32'h08, 4'h0, 32'h0, 32'h0}, '{32'h0C, 4'h0, 32'h0, 32'h0},
      '{32'h10, 4'h0, 32'h0, 32'h0},
      '{32'h04, 4'hF, 32'hFFFF_1234, 32'h0}, '{32'h04, 4'h0, 32'h0, 32'h0000_1234},
      '{32'h00, 4'hF, 32'hFFFF_FFF8, 32'h0}, '{32'h00, 4'h0, 32'h0, 32'h0},
      '{32'h08, 4'hF, 32'hAABB_CCDD, 32'h0}, '{32'h08, 4'b0010, 32'h0000_1100, 32'h0},
      '{32'h08, 4'h0, 32'h0, 32'hAABB_11DD},
      '{32'h0C, 4'b1000, 32'h5A12_3456, 32'h0}, '{32'h0C, 4'h0, 32'h0, 32'h5A00_0000},
      '{32'h14, 4'hF, 32'hFFFF_FFFF, 32'h0}, '{32'h14, 4'h0, 32'h0, 32'h0},
      '{32'h1C, 4'h0, 32'h0, 32'h0}, '{32'h0B, 4'h0, 32'h0, 32'hAABB_11DD},
      '{32'h10, 4'hF, 32'h1, 32'h0}, '{32'h10, 4'h0, 32'h0, 32'h0}
    };
    foreach (vt[i]) begin
      bus_xfer(BASE + vt[i].off, vt[i].strb, vt[i].wdata, rd, lat);
      check("vec_latency", lat, 1);
      if (vt[i].strb == 4'h0) check("vec_rdata", rd, vt[i].exp);
    end

    // Periodic mode: pending every 20 clk, irq one cycle later
    wr(32'h04, 32'd3); wr(32'h08, 32'd4); wr(32'h0C, 32'd4);
    c0 = cyc + 1;
    wr(32'h00, 32'h7);
    wait_irq(c1);
    check("periodic_first", c1 - c0, 21);
    wr(32'h10, 32'h1);
    step();
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wait_irq(c2);
    check("periodic_interval", c2 - c1, 20);
    wr(32'h00, 32'h0); wr(32'h10, 32'h1);

    // One-shot: expires after 3 ticks and disables itself
    wr(32'h04, 32'd0); wr(32'h0C, 32'd2); wr(32'h00, 32'h1);
    step(); step();
    rd_chk("oneshot_pending", 32'h10, 32'h1);
    rd_chk("oneshot_ctrl", 32'h00, 32'h0);
    rd_chk("oneshot_count", 32'h0C, 32'h0);
    wr(32'h10, 32'h1);
    repeat (100) step();
    rd_chk("oneshot_no_reexpire", 32'h10, 32'h0);

    // W1C landing on the expiry edge: set wins
    wr(32'h08, 32'd50); wr(32'h0C, 32'd3); wr(32'h00, 32'h3);
    step(); step();
    wr(32'h10, 32'h1);
    rd_chk("w1c_vs_expiry", 32'h10, 32'h1);
    wr(32'h00, 32'h0); wr(32'h10, 32'h1);

    // COUNT write on a tick edge: write wins, next tick decrements
    wr(32'h04, 32'd3); wr(32'h08, 32'd100); wr(32'h0C, 32'd20); wr(32'h00, 32'h3);
    step(); step();
    wr(32'h0C, 32'd9);
    rd_chk("count_write_wins", 32'h0C, 32'd9);
    step(); step();
    rd_chk("count_after_tick", 32'h0C, 32'd8);
    wr(32'h00, 32'h0);

    // Access outside the window never acks
    acks = 0;
    bus.valid = 1'b1; bus.addr = 32'h0200_0008; bus.wstrb = 4'h0;
    repeat (5) begin step(); if (bus.ready === 1'b1) acks++; check("outside_rdata", bus.rdata, 32'd0); end
    bus.valid = 1'b0; step();
    check("outside_no_ack", acks, 0);

    // Held valid gets exactly one ack
    acks = 0;
    bus.valid = 1'b1; bus.addr = BASE + 32'h0C;
    repeat (5) begin step(); if (bus.ready === 1'b1) acks++; end
    bus.valid = 1'b0; step(); step();
    check("held_one_ack", acks, 1);

    // Reset during a pending request drops it; request acked after release
    bus.valid = 1'b1; bus.addr = BASE; sreset = 1'b1;
    step();
    check("reset_drop_ready", {31'd0, bus.ready}, 32'd0);
    sreset = 1'b0;
    step();
    check("reset_reissue_ack", {31'd0, bus.ready}, 32'd1);
    bus.valid = 1'b0; step();

    // Randomized traffic checked cycle by cycle against the model
    for (int t = 0; t < 600; t++) begin
      logic [31:0] off, data;
      logic [3:0]  strb;
      bit outside;
      off  = 32'($urandom_range(0, 7)) << 2;
      outside = ($urandom_range(0, 19) == 0);
      strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      case (off)
        32'h00: data = 32'($urandom_range(0, 7));
        32'h04: data = 32'($urandom_range(0, 3));
        32'h08, 32'h0C: data = 32'($urandom_range(0, 7));
        default: data = $urandom;
      endcase
      bus_xfer(outside ? (32'h0400_0000 + off) : (BASE + off), strb, data, rd, lat);
      check("rand_latency", lat, outside ? -1 : 1);
      if ($urandom_range(0, 59) == 0) begin sreset = 1'b1; step(); sreset = 1'b0; end
      repeat ($urandom_range(0, 4)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
